// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and the result flag bundle.
package alu_pkg;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } alu_flags_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational SW-bit ripple slice; b is inverted for subtraction, the +1 enters via cin.
module addsub_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    input  logic          invert,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          c_msb_in
);

    logic [SW-1:0] b_eff;
    logic [SW:0]   c;

    assign b_eff = invert ? ~b : b;
    assign c[0]  = cin;

    for (genvar i = 0; i < SW; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b_eff[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout     = c[SW];
    assign c_msb_in = c[SW-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the carry chain of each slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: one carry-chained slice per stage, operands skewed
// forward, result slices accumulated so the last stage presents the full word and flags.
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i_1,
    input  logic [WIDTH-1:0] i_2,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             zero_flag,
    output logic             negative_flag
);

    localparam int SW = WIDTH / STAGES;

    // Valid/ready: a beat moves on any edge where valid & ready are both high.
    // The whole pipe advances as one unit, so empty stages are never collapsed.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam int PW = WIDTH - LO;

        logic [PW-1:0]      a_pend;
        logic [PW-1:0]      b_pend;
        logic [LO+SW-1:0]   res_d;
        logic [LO+SW-1:0]   res_q;
        logic [SW-1:0]      s;
        logic               op_in;
        logic               cin;
        logic               v_in;
        logic               cout;
        logic               c_msb;
        logic               v_q;

        if (k == 0) begin : g_head
            assign a_pend = i_1;
            assign b_pend = i_2;
            assign op_in  = op;
            assign cin    = (op == ALU_OP_SUB);
            assign v_in   = in_valid;
            assign res_d  = s;
        end else begin : g_body
            assign a_pend = g_stage[k-1].g_skew.a_q;
            assign b_pend = g_stage[k-1].g_skew.b_q;
            assign op_in  = g_stage[k-1].g_skew.op_q;
            assign cin    = g_stage[k-1].g_skew.c_q;
            assign v_in   = g_stage[k-1].v_q;
            assign res_d  = {s, g_stage[k-1].res_q};
        end

        addsub_slice #(.SW(SW)) u_slice (
            .a        (a_pend[SW-1:0]),
            .b        (b_pend[SW-1:0]),
            .cin      (cin),
            .invert   (op_in == ALU_OP_SUB),
            .s        (s),
            .cout     (cout),
            .c_msb_in (c_msb)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                res_q <= '0;
            end else if (adv) begin
                v_q   <= v_in;
                res_q <= res_d;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [PW-SW-1:0] a_q;
            logic [PW-SW-1:0] b_q;
            logic             op_q;
            logic             c_q;
            // Carry into a lower slice's MSB has no meaning for the flags.
            logic             c_msb_unused;
            assign c_msb_unused = c_msb;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    op_q <= 1'b0;
                    c_q  <= 1'b0;
                end else if (adv) begin
                    a_q  <= a_pend[PW-1:SW];
                    b_q  <= b_pend[PW-1:SW];
                    op_q <= op_in;
                    c_q  <= cout;
                end
            end
        end else begin : g_last
            alu_flags_t flags_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    flags_q <= '0;
                end else if (adv) begin
                    flags_q.carry    <= cout;
                    flags_q.overflow <= cout ^ c_msb;
                    flags_q.zero     <= (res_d == '0);
                    flags_q.negative <= res_d[WIDTH-1];
                end
            end
        end
    end

    assign out_valid     = g_stage[STAGES-1].v_q;
    assign o             = g_stage[STAGES-1].res_q;
    assign carry_flag    = g_stage[STAGES-1].g_last.flags_q.carry;
    assign overflow_flag = g_stage[STAGES-1].g_last.flags_q.overflow;
    assign zero_flag     = g_stage[STAGES-1].g_last.flags_q.zero;
    assign negative_flag = g_stage[STAGES-1].g_last.flags_q.negative;

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the 32-bit ripple adder in the ALU datapath.
- Splits the WIDTH-bit add/subtract into STAGES carry-chained slices, one slice per pipeline stage.
- Operands are skewed through the pipeline; results are de-skewed at the output.
- Has a valid/ready handshake with back-pressure and reports carry, signed overflow, zero and negative flags per result.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, pipeline depth and slice count; slice width SW = WIDTH/STAGES; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- i_1  input  WIDTH  operand A.
- i_2  input  WIDTH  operand B.
- op  input  1  0 = ADD (A+B), 1 = SUB (A-B = A + ~B + 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- o  output  WIDTH  sum/difference, modulo 2^WIDTH.
- carry_flag  output  1  carry out of MSB; for SUB, 1 means no borrow (A >= B unsigned).
- overflow_flag  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero_flag  output  1  o == 0.
- negative_flag  output  1  o[WIDTH-1].

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset: all stage valid bits clear; out_valid=0, o=0, all flags 0.
  - in_ready = 1 when rst deasserts.
  - Data registers also clear.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv (combinational; no dependence on in_valid).
- Transfer: an input beat is taken when in_valid & in_ready. An output beat is consumed when out_valid & out_ready.
- While adv=0, every stage register (data, valid, carry, skew) holds.
- Bubbles are not collapsed: a stalled pipeline with empty stages stays stalled until out_ready.
- Stage k (0..STAGES-1), on adv:
  - computes bits [k*SW +: SW] from A-slice, B-slice (inverted if op_k=1) and carry-in.
  - Carry-in of stage 0 = op. Carry-in of stage k>0 = the registered carry-out of stage k-1.
  - op travels with the beat.
- Skew: untouched upper slices of A/B/op ride along in stage registers; completed lower result slices also ride along. Stage k holds only the bits still needed.
- Latency: exactly STAGES cycles from accept to out_valid when never stalled. Throughput: 1 beat/cycle while out_ready=1.
- Flags are computed in the last stage from the MSB slice and registered with o. A flag is never valid without its result.
- overflow_flag needs the carry into bit WIDTH-1, taken inside the MSB slice.
- Valid bits shift on adv. A cycle with adv=1 and no accepted input inserts a bubble (valid=0).
- Simultaneous accept and drain in the same cycle is legal: full throughput, no data loss.
- rst asserted mid-operation: all in-flight beats are discarded immediately (async), with no partial output.
- STAGES=1 degenerates to a single registered adder with 1-cycle latency.
- Outputs o and flags hold stable while out_valid=1 & out_ready=0.

Decomposition:
- Shared package alu_pkg:
  - op encoding constants ALU_OP_ADD=1'b0, ALU_OP_SUB=1'b1.
  - Flag struct typedef {carry, overflow, zero, negative}.
- Natural sub-module: addsub_slice. Combinational SW-bit slice built from the existing full_adder cells. Inputs: a, b, cin, invert. Outputs: s, cout, and c_msb_in (carry into the slice MSB, used only by the top slice).
- Top level holds the generate loop of stage registers, skew/de-skew, valid chain and handshake.

Test Plan:
- WIDTH=32, STAGES=4, ADD 0x0000_0001 + 0xFFFF_FFFF, out_ready=1 -> after 4 cycles: o=0, carry=1, zero=1, overflow=0, negative=0.
- ADD 0x7FFF_FFFF + 0x0000_0001 -> o=0x8000_0000, overflow=1, negative=1, carry=0.
- SUB 5 - 7 -> o=0xFFFF_FFFE, carry=0 (borrow), negative=1, overflow=0. SUB 7 - 7 -> o=0, zero=1, carry=1.
- Back-to-back 8 beats, out_ready toggling 1,0,0,1,...:
  - results appear in order and match the reference model.
  - in_ready tracks ~out_valid | out_ready.
  - no beat is lost or duplicated.
  - o is stable while stalled.
- Carry crossing every slice boundary: ADD 0x00FF_FFFF + 1 -> 0x0100_0000. Also run STAGES=1, 2, 8, 32 builds with random operands -> scoreboard match.
- Fill the pipeline with 4 beats, hold out_ready=0, assert rst for 1 cycle -> out_valid drops immediately. After release, in_ready=1 and no stale beat ever appears.
